// File: rtl/unary_stream_decoder.sv
// Decodes LANES unary bitstreams to binary by counting ones over a WINDOW-cycle window.
// state | meaning
// IDLE  | waiting for start; start_ready=1
// COUNT | window in progress; lane counters accumulate stream_in
// HOLD  | value valid until consumer takes it; start_ready follows out_ready
module unary_stream_decoder #(
  parameter int LANES     = 4,
  parameter int OUT_WIDTH = 8,
  parameter int WINDOW    = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  output logic                              start_ready,
  input  logic [LANES-1:0]                  stream_in,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0][OUT_WIDTH-1:0]   value
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  if (WINDOW < 1 || WINDOW > (2 ** OUT_WIDTH) - 1) begin : g_bad_window
    $error("unary_stream_decoder: WINDOW out of range 1..2**OUT_WIDTH-1");
  end

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t                          state;
  logic [CW-1:0]                   win_cnt;
  logic [CW-1:0]                   next_idx;
  logic [LANES-1:0][OUT_WIDTH-1:0] lane_cnt;
  logic [LANES-1:0][OUT_WIDTH-1:0] lane_next;
  logic                            accept;

  assign start_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept      = start && start_ready;
  assign busy        = (state == COUNT);
  assign out_valid   = (state == HOLD);
  assign next_idx    = win_cnt + CW'(1);

  // Outside COUNT this is the sample-0 load used when a start is accepted.
  always_comb begin
    lane_next = lane_cnt;
    for (int i = 0; i < LANES; i++) begin
      if (state == COUNT)
        lane_next[i] = lane_cnt[i] + OUT_WIDTH'(stream_in[i]);
      else
        lane_next[i] = OUT_WIDTH'(stream_in[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      lane_cnt <= '0;
      value    <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            win_cnt  <= '0;
            lane_cnt <= lane_next;
            if (WINDOW == 1) begin
              value <= lane_next;
              state <= HOLD;
            end else begin
              state <= COUNT;
            end
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        COUNT: begin
          lane_cnt <= lane_next;
          win_cnt  <= next_idx;
          if (next_idx == LAST) begin
            value <= lane_next;
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboard bench for unary_stream_decoder: WINDOW=7, WINDOW=1 and WINDOW=255 instances.
module tb_unary_stream_decoder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // instance a: OUT_WIDTH=3, WINDOW=7
  logic            a_start, a_sr, a_busy, a_ov, a_or;
  logic [3:0]      a_in;
  logic [3:0][2:0] a_val;
  // instance b: OUT_WIDTH=3, WINDOW=1
  logic            b_start, b_sr, b_busy, b_ov, b_or;
  logic [3:0]      b_in;
  logic [3:0][2:0] b_val;
  // instance c: OUT_WIDTH=8, WINDOW=255
  logic            c_start, c_sr, c_busy, c_ov, c_or;
  logic [3:0]      c_in;
  logic [3:0][7:0] c_val;

  unary_stream_decoder #(.LANES(4), .OUT_WIDTH(3), .WINDOW(7)) u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .start_ready(a_sr),
    .stream_in(a_in), .busy(a_busy), .out_valid(a_ov), .out_ready(a_or), .value(a_val));

  unary_stream_decoder #(.LANES(4), .OUT_WIDTH(3), .WINDOW(1)) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .start_ready(b_sr),
    .stream_in(b_in), .busy(b_busy), .out_valid(b_ov), .out_ready(b_or), .value(b_val));

  unary_stream_decoder #(.LANES(4), .OUT_WIDTH(8), .WINDOW(255)) u_c (
    .clk(clk), .reset_n(reset_n), .start(c_start), .start_ready(c_sr),
    .stream_in(c_in), .busy(c_busy), .out_valid(c_ov), .out_ready(c_or), .value(c_val));

  int checks = 0;
  int errors = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];
  logic [31:0] a_shown;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_a(input logic [6:0] p0, input logic [6:0] p1,
                                        input logic [6:0] p2, input logic [6:0] p3);
    return 32'({3'($countones(p3)), 3'($countones(p2)), 3'($countones(p1)), 3'($countones(p0))});
  endfunction

  // Pops the scoreboard for any handshake about to complete, then advances one cycle.
  task automatic step();
    logic [31:0] e;
    if (a_ov && a_or) begin
      check_val("a_sb_nonempty", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check_val("a_value", 32'(a_val), e);
      end
    end
    if (b_ov && b_or) begin
      check_val("b_sb_nonempty", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check_val("b_value", 32'(b_val), e);
      end
    end
    if (c_ov && c_or) begin
      check_val("c_sb_nonempty", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        check_val("c_value", 32'(c_val), e);
      end
    end
    check_val("b_never_busy", 32'(b_busy), 0);
    @(negedge clk);
  endtask

  // Drives a full 7-sample window on instance a starting this cycle; pattern bit 6 is sample 0.
  task automatic a_window(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                          input logic [6:0] p3, input logic [31:0] exp);
    a_start = 1'b1;
    a_in = {p3[6], p2[6], p1[6], p0[6]};
    q_a.push_back(exp);
    for (int k = 1; k < 7; k++) begin
      step();
      a_start = 1'b0;
      check_val("a_busy", 32'(a_busy), 1);
      check_val("a_old_value", 32'(a_val), a_shown);
      a_in = {p3[6-k], p2[6-k], p1[6-k], p0[6-k]};
    end
    step();
    a_in = 4'bxxxx;
    check_val("a_latency_ov", 32'(a_ov), 1);
    check_val("a_busy_end", 32'(a_busy), 0);
    a_shown = exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_start = 0; a_or = 0; a_in = 0;
    b_start = 0; b_or = 0; b_in = 0;
    c_start = 0; c_or = 0; c_in = 0;
    a_shown = 0;
    repeat (2) @(negedge clk);
    check_val("rst_a_sr", 32'(a_sr), 1);
    check_val("rst_a_busy", 32'(a_busy), 0);
    check_val("rst_a_ov", 32'(a_ov), 0);
    check_val("rst_a_val", 32'(a_val), 0);
    check_val("rst_c_val", 32'(c_val), 0);
    reset_n = 1'b1;
    step();

    // basic decode
    a_or = 1'b1;
    a_window(7'b0000000, 7'b1111111, 7'b1010100, 7'b0000001, 32'({3'd1, 3'd3, 3'd7, 3'd0}));
    step();
    check_val("t1_idle_ov", 32'(a_ov), 0);
    check_val("t1_idle_sr", 32'(a_sr), 1);

    // backpressure with a dropped start
    a_or = 1'b0;
    a_window(7'b1010101, 7'b1010101, 7'b1010101, 7'b1010101,
             cnt_a(7'b1010101, 7'b1010101, 7'b1010101, 7'b1010101));
    for (int c = 0; c < 5; c++) begin
      check_val("t2_sr", 32'(a_sr), 0);
      check_val("t2_ov", 32'(a_ov), 1);
      check_val("t2_val_held", 32'(a_val), a_shown);
      a_start = (c == 2);
      a_in = 4'hf;
      step();
    end
    a_start = 1'b0;
    a_or = 1'b1;
    step();
    check_val("t2_ov_drop", 32'(a_ov), 0);
    check_val("t2_not_busy", 32'(a_busy), 0);
    check_val("t2_sr_idle", 32'(a_sr), 1);
    step();
    check_val("t2_start_dropped", 32'(a_busy), 0);

    // back-to-back windows
    a_or = 1'b0;
    a_window(7'b1100000, 7'b1110000, 7'b0000000, 7'b1111110,
             cnt_a(7'b1100000, 7'b1110000, 7'b0000000, 7'b1111110));
    a_or = 1'b1;
    a_window(7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 32'({3'd7, 3'd7, 3'd7, 3'd7}));
    step();
    check_val("t3_ov_drop", 32'(a_ov), 0);

    // reset mid-window
    a_start = 1'b1;
    a_in = 4'hf;
    step();
    a_start = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_val("t4_sr", 32'(a_sr), 1);
    check_val("t4_busy", 32'(a_busy), 0);
    check_val("t4_ov", 32'(a_ov), 0);
    check_val("t4_val", 32'(a_val), 0);
    @(negedge clk);
    reset_n = 1'b1;
    a_shown = 0;
    a_in = 4'bxxxx;
    step();
    a_window(7'b0101010, 7'b0101010, 7'b0101010, 7'b0101010, 32'({3'd3, 3'd3, 3'd3, 3'd3}));
    step();

    // WINDOW=1, including a back-to-back start in HOLD
    b_or = 1'b1;
    b_start = 1'b1;
    b_in = 4'b1010;
    q_b.push_back(32'({3'd1, 3'd0, 3'd1, 3'd0}));
    step();
    check_val("t5_ov", 32'(b_ov), 1);
    b_in = 4'b0111;
    q_b.push_back(32'({3'd0, 3'd1, 3'd1, 3'd1}));
    step();
    check_val("t5_b2b_ov", 32'(b_ov), 1);
    b_start = 1'b0;
    b_in = 4'bxxxx;
    step();
    check_val("t5_ov_drop", 32'(b_ov), 0);

    // boundary count, WINDOW=255
    c_or = 1'b1;
    c_start = 1'b1;
    c_in = 4'b0001;
    q_c.push_back(32'({8'd0, 8'd0, 8'd0, 8'd255}));
    for (int k = 1; k < 255; k++) begin
      step();
      c_start = 1'b0;
      check_val("c_busy", 32'(c_busy), 1);
    end
    step();
    c_in = 4'bxxxx;
    check_val("t6_ov", 32'(c_ov), 1);
    step();
    check_val("t6_ov_drop", 32'(c_ov), 0);

    check_val("a_sb_drained", q_a.size(), 0);
    check_val("b_sb_drained", q_b.size(), 0);
    check_val("c_sb_drained", q_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
